router_fifo: RTL and testbench



---
 rtl/router_fifo.sv | 81 ++++++++
 tb/tb_router_fifo.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/router_fifo.sv
// Per-destination output buffer of the 1x3 router: stores header/payload/parity bytes,
// tags headers, and returns data_out to idle once a packet has been fully read.
module router_fifo #(
  parameter int DEPTH  = 16,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             read_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH:0]   mem_q [0:DEPTH-1];
  logic [ADDR_W:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]  rd_ptr_q, rd_ptr_d;
  logic [6:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH:0]   rd_entry;
  logic             wr_acc, rd_acc, mem_we;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                    (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
  assign data_out = dout_q;

  assign wr_acc   = write_enb && !full;
  assign rd_acc   = read_enb && !empty;
  assign rd_entry = mem_q[rd_ptr_q[ADDR_W-1:0]];
  // A write coinciding with either reset must not land, even though it would be unreachable.
  assign mem_we   = wr_acc && resetn && !soft_reset;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    if (soft_reset) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      dout_d   = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        dout_d   = rd_entry[WIDTH-1:0];
        // Header carries payload length in [7:2]; +1 covers the trailing parity byte.
        if (rd_entry[WIDTH])   cnt_d = 7'(rd_entry[WIDTH-1:2]) + 7'd1;
        else if (cnt_q != '0) cnt_d = cnt_q - 7'd1;
      end else if (cnt_q == '0) begin
        dout_d = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) mem_q[wr_ptr_q[ADDR_W-1:0]] <= {lfd_state, data_in};
  end

endmodule

// File: tb/tb_router_fifo.sv
// Directed bench for router_fifo: a vector table for reset and a single packet,
// then hand sequences for fill/overflow, full read+write, wrap-around and soft reset.
module tb_router_fifo;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       soft_reset = 1'b0;
  logic       write_enb = 1'b0;
  logic       read_enb = 1'b0;
  logic       lfd_state = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       full;
  logic       empty;
  logic [7:0] data_out;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  router_fifo #(.DEPTH(16), .WIDTH(8), .ADDR_W(4)) dut (
    .clock(clock), .resetn(resetn), .soft_reset(soft_reset),
    .write_enb(write_enb), .read_enb(read_enb), .lfd_state(lfd_state),
    .data_in(data_in), .full(full), .empty(empty), .data_out(data_out)
  );

  typedef struct {
    logic       rn, srst, we, re, lfd;
    logic [7:0] din;
    logic       exp_full, exp_empty;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t vecs [16];

  logic [7:0] pkt_q [$];
  logic       hdr_q [$];

  task automatic drive(input logic rn, input logic sr, input logic we, input logic re,
                       input logic lfd, input logic [7:0] din);
    @(negedge clock);
    resetn = rn; soft_reset = sr; write_enb = we; read_enb = re;
    lfd_state = lfd; data_in = din;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic ef, input logic ee, input logic [7:0] ed);
    n_checks++;
    if (full !== ef || empty !== ee || data_out !== ed) begin
      n_fail++;
      $display("FAIL %s: got full=%b empty=%b data_out=%h, want full=%b empty=%b data_out=%h",
               name, full, empty, data_out, ef, ee, ed);
    end
  endtask

  task automatic add_packet(input logic [5:0] len, input logic [7:0] seed);
    logic [7:0] hdr, par, b;
    hdr = {len, 2'b01};
    par = hdr;
    pkt_q.push_back(hdr); hdr_q.push_back(1'b1);
    for (int j = 0; j < int'(len); j++) begin
      b = seed + 8'(j);
      par = par ^ b;
      pkt_q.push_back(b); hdr_q.push_back(1'b0);
    end
    pkt_q.push_back(par); hdr_q.push_back(1'b0);
  endtask

  initial begin
    // rn srst we re lfd din | full empty dout ; parity of 0D,A1,A2,A3 is AD
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h0D, 1'b0, 1'b0, 8'h00};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA1, 1'b0, 1'b0, 8'h00};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA2, 1'b0, 1'b0, 8'h00};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA3, 1'b0, 1'b0, 8'h00};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hAD, 1'b0, 1'b0, 8'h00};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h0D};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA1};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA1};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA2};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA3};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'hAD};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00};

    for (int v = 0; v < 16; v++) begin
      drive(vecs[v].rn, vecs[v].srst, vecs[v].we, vecs[v].re, vecs[v].lfd, vecs[v].din);
      check($sformatf("vec%0d", v), vecs[v].exp_full, vecs[v].exp_empty, vecs[v].exp_dout);
    end

    // Fill with 01..11; the 17th write is dropped
    for (int i = 1; i <= 17; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'(i));
      check($sformatf("fill%0d", i), (i >= 16), 1'b0, 8'h00);
    end
    // Full: read proceeds, write of 55 dropped
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h55);
    check("full_rw", 1'b0, 1'b0, 8'h01);
    for (int i = 2; i <= 16; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      check($sformatf("drain%0d", i), 1'b0, (i == 16), 8'(i));
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("drain_idle", 1'b0, 1'b1, 8'h00);

    // Wrap-around: 3 packets, 40 bytes, reading 3 behind the writer
    add_packet(6'd10, 8'h20);
    add_packet(6'd12, 8'h40);
    add_packet(6'd12, 8'h80);
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 1'b0, 1'b1, (i >= 3), hdr_q[i], pkt_q[i]);
      check($sformatf("wrap_w%0d", i), 1'b0, 1'b0, (i >= 3) ? pkt_q[i-3] : 8'h00);
    end
    for (int k = 37; k < 40; k++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      check($sformatf("wrap_r%0d", k), 1'b0, (k == 39), pkt_q[k]);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("wrap_idle", 1'b0, 1'b1, 8'h00);

    // Soft reset mid-packet: header 11 (length 4) plus 5 bytes stored, 2 read
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11);
    for (int i = 1; i <= 5; i++) drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hB0 + 8'(i));
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    check("sr_rd_hdr", 1'b0, 1'b0, 8'h11);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    check("sr_rd_b1", 1'b0, 1'b0, 8'hB1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hEE);
    check("sr_flush", 1'b0, 1'b1, 8'h00);
    // A stale count would hold 77 on the idle cycle instead of returning to 00
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h77);
    check("sr_wr77", 1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    check("sr_rd77", 1'b0, 1'b1, 8'h77);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("sr_cnt0", 1'b0, 1'b1, 8'h00);
    // Clean packet after flush: header 05 (length 1), payload C1, parity C4
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h05);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hC1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hC4);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    check("post_hdr", 1'b0, 1'b0, 8'h05);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    check("post_pay", 1'b0, 1'b0, 8'hC1);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    check("post_par", 1'b0, 1'b1, 8'hC4);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("post_idle", 1'b0, 1'b1, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
